// File: rtl/sysbus_mem_responder.sv
// Sysbus memory-side responder: accepts one request at a time, acknowledges
// it, then absorbs a write burst or returns a read burst after a fixed latency.
module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 1024,
  parameter int BEATS          = 8,
  parameter int LATENCY        = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack,
  output logic                      busy
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW = $clog2(LATENCY + 1);
  localparam logic [AW-1:0] LINE_MASK = AW'(BEATS - 1);
  localparam logic [3:0]    DEV_MEM   = 4'b0001;

  typedef enum logic [2:0] {IDLE, ACK, WDATA, LWAIT, RESP} state_t;

  state_t                     state;
  logic [AW-1:0]              base;
  logic [BUS_TAG_WIDTH-1:0]   tag;
  logic [BW-1:0]              beat;
  logic [LW-1:0]              lat;

  // Zero at time 0; reset deliberately leaves contents alone.
  logic [BUS_DATA_WIDTH-1:0]  mem [0:MEM_WORDS-1] = '{default: '0};

  logic                       is_mem;
  logic                       is_read;
  logic                       last_beat;
  logic                       mem_we;
  logic [AW-1:0]              cur_idx;
  logic [AW-1:0]              next_idx;

  // Burst addressing: base is line-aligned, so OR-ing in the beat keeps the
  // index inside the aligned line.
  always_comb begin
    is_mem    = (tag[11:8] == DEV_MEM);
    is_read   = tag[12];
    last_beat = (beat == BW'(BEATS - 1));
    cur_idx   = base | AW'(beat);
    next_idx  = base | AW'(beat + 1'b1);
    mem_we    = (state == WDATA) && bus_reqcyc && is_mem;
  end

  // Memory write port: one word per accepted write-data beat.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[cur_idx] <= bus_req;
    end
  end

  // Transaction FSM with registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bus_reqack  <= 1'b0;
      bus_respcyc <= 1'b0;
      bus_resp    <= '0;
      bus_resptag <= '0;
      busy        <= 1'b0;
      beat        <= '0;
      lat         <= '0;
      base        <= '0;
      tag         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus_reqcyc) begin
            base       <= bus_req[3 +: AW] & ~LINE_MASK;
            tag        <= bus_reqtag;
            bus_reqack <= 1'b1;
            busy       <= 1'b1;
            state      <= ACK;
          end
        end
        ACK: begin
          bus_reqack <= 1'b0;
          beat       <= '0;
          if (is_read) begin
            lat   <= LW'(LATENCY);
            state <= LWAIT;
          end else begin
            state <= WDATA;
          end
        end
        WDATA: begin
          if (bus_reqcyc) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              beat  <= '0;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        LWAIT: begin
          lat <= lat - 1'b1;
          if (lat == LW'(1)) begin
            bus_respcyc <= 1'b1;
            bus_resptag <= tag;
            bus_resp    <= is_mem ? mem[cur_idx] : '0;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus_respack) begin
            if (last_beat) begin
              bus_respcyc <= 1'b0;
              bus_resp    <= '0;
              bus_resptag <= '0;
              busy        <= 1'b0;
              beat        <= '0;
              state       <= IDLE;
            end else begin
              beat     <= beat + 1'b1;
              bus_resp <= is_mem ? mem[next_idx] : '0;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Directed self-checking bench for sysbus_mem_responder.
module tb_sysbus_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  sysbus_mem_responder #(
    .BUS_DATA_WIDTH(64),
    .BUS_TAG_WIDTH (13),
    .MEM_WORDS     (1024),
    .BEATS         (8),
    .LATENCY       (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_reqcyc (bus_reqcyc),
    .bus_req    (bus_req),
    .bus_reqtag (bus_reqtag),
    .bus_reqack (bus_reqack),
    .bus_respcyc(bus_respcyc),
    .bus_resp   (bus_resp),
    .bus_resptag(bus_resptag),
    .bus_respack(bus_respack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request from an idle responder; returns in the ACK cycle.
  task automatic do_req(input logic [63:0] addr, input logic [12:0] t);
    int n;
    bus_reqcyc = 1'b1;
    bus_req    = addr;
    bus_reqtag = t;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus_reqack && n < 10);
    check("reqack_lat", 64'(n), 64'd1);
    check("busy_in_ack", 64'(busy), 64'd1);
    bus_reqcyc = 1'b0;
    bus_req    = '0;
  endtask

  // Write burst; optional 2-cycle reqcyc stall after beat stall_after.
  task automatic write_burst(input logic [63:0] addr, input logic [12:0] t,
                             input logic [63:0] first, input int stall_after);
    do_req(addr, t);
    tick();
    for (int i = 0; i < 8; i++) begin
      bus_reqcyc = 1'b1;
      bus_req    = first + 64'(i);
      tick();
      if (i == stall_after) begin
        bus_reqcyc = 1'b0;
        tick();
        tick();
        check("wr_stall_busy", 64'(busy), 64'd1);
      end
    end
    bus_reqcyc = 1'b0;
    bus_req    = '0;
    check("wr_end_busy", 64'(busy), 64'd0);
    check("wr_no_ack", 64'(bus_reqack), 64'd0);
  endtask

  // Read burst; mode 0 holds respack high, mode 1 acks every third cycle.
  task automatic read_burst(input logic [63:0] addr, input logic [12:0] t,
                            input logic [63:0] first, input logic zero, input int mode);
    int n, k, cyc;
    logic ack;
    logic [63:0] exp;
    do_req(addr, t);
    if (mode == 0) bus_respack = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus_respcyc && n < 20);
    check("resp_lat", 64'(n), 64'd5);
    k = 0;
    cyc = 0;
    while (bus_respcyc && cyc < 64) begin
      exp = zero ? 64'd0 : first + 64'(k);
      check("beat_data", bus_resp, exp);
      check("beat_tag", 64'(bus_resptag), 64'(t));
      ack = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      bus_respack = ack;
      tick();
      if (ack) k++;
      cyc++;
    end
    bus_respack = 1'b0;
    check("beat_count", 64'(k), 64'd8);
    check("burst_cycles", 64'(cyc), (mode == 0) ? 64'd8 : 64'd22);
    check("end_respcyc", 64'(bus_respcyc), 64'd0);
    check("end_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    reset       = 1'b1;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    repeat (3) tick();
    check("rst_reqack", 64'(bus_reqack), 64'd0);
    check("rst_respcyc", 64'(bus_respcyc), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp", bus_resp, 64'd0);
    check("rst_resptag", 64'(bus_resptag), 64'd0);
    reset = 1'b0;
    tick();

    // Read of zero memory
    read_burst(64'h40, 13'h1100, 64'd0, 1'b1, 0);

    // Back-to-back write then full-rate read
    write_burst(64'h80, 13'h0100, 64'h1000, -1);
    read_burst(64'h80, 13'h1100, 64'h1000, 1'b0, 0);

    // Stalled read
    read_burst(64'h80, 13'h1100, 64'h1000, 1'b0, 1);

    // Unaligned and wrapped addresses hit the same line
    read_burst(64'h9B, 13'h1100, 64'h1000, 1'b0, 0);
    read_burst(64'h2080, 13'h1100, 64'h1000, 1'b0, 0);

    // Write with stall, then reset during read latency
    write_burst(64'hC0, 13'h0100, 64'h5000, 3);
    read_burst(64'hC0, 13'h1100, 64'h5000, 1'b0, 0);
    do_req(64'h80, 13'h1100);
    bus_reqcyc = 1'b1;
    tick();
    check("ignored_req0", 64'(bus_reqack), 64'd0);
    tick();
    check("ignored_req1", 64'(bus_reqack), 64'd0);
    bus_reqcyc = 1'b0;
    reset = 1'b1;
    tick();
    check("mid_rst_respcyc", 64'(bus_respcyc), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_respcyc", 64'(bus_respcyc), 64'd0);
      check("post_rst_busy", 64'(busy), 64'd0);
    end
    read_burst(64'h80, 13'h1100, 64'h1000, 1'b0, 0);

    // Non-memory device: zero reads, discarded writes
    read_burst(64'h80, 13'h12AB, 64'd0, 1'b1, 0);
    write_burst(64'h80, 13'h02AB, 64'hDEAD0000, -1);
    read_burst(64'h80, 13'h1100, 64'h1000, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
